// File: rtl/waterbear_bus_arbiter.sv
// Memory-bus arbiter for the waterbear CPU: shares one fixed-latency single-port
// memory between instruction fetch and data load/store, data first, with a fetch starvation guard.
module waterbear_bus_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT4    = 4'(MEM_LAT);
    localparam logic [3:0] STARVE4 = 4'(STARVE_MAX);

    state_t        state_q, state_d;
    logic          own_d_q, own_d_d;   // 1 = data requester owns the access
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    starve_q, starve_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          fetch_wins;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            own_d_q  <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            starve_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            own_d_q  <= own_d_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        own_d_d    = own_d_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        fetch_wins = if_req && (!d_req || starve_q == STARVE4);

        case (state_q)
            IDLE, DONE: begin
                if (if_req || d_req) begin
                    state_d = ISSUE;
                    own_d_d = !fetch_wins;
                    if (fetch_wins) begin
                        addr_d = if_addr;
                        we_d   = 1'b0;
                    end else begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end
                    // Only a pending fetch that loses accumulates starvation.
                    if (fetch_wins || !if_req)
                        starve_d = '0;
                    else if (starve_q < STARVE4)
                        starve_d = starve_q + 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = LAT4;
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    if (!we_q)
                        rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign mem_en    = (state_q == ISSUE);
    assign if_gnt    = mem_en && !own_d_q;
    assign d_gnt     = mem_en && own_d_q;
    assign if_valid  = (state_q == DONE) && !own_d_q;
    assign d_valid   = (state_q == DONE) && own_d_q;
    assign busy      = (state_q != IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_waterbear_bus_arbiter.sv
// Bench for waterbear_bus_arbiter: timestamp-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized requester traffic.
module tb_waterbear_bus_arbiter;

    localparam int LAT  = 1;
    localparam int SMAX = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       if_req, d_req, d_we;
    logic [7:0] if_addr, d_addr, d_wdata;
    logic       if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic       b_d_req;
    logic [7:0] b_d_addr;
    logic       b_if_gnt, b_if_valid, b_d_gnt, b_d_valid, b_mem_en, b_mem_we, b_busy;
    logic [7:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    waterbear_bus_arbiter #(.AW(8), .DW(8), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    waterbear_bus_arbiter #(.AW(8), .DW(8), .MEM_LAT(4), .STARVE_MAX(2)) dut_b (
        .clk(clk), .reset(rst),
        .if_req(1'b0), .if_addr(8'h00), .if_gnt(b_if_gnt), .if_valid(b_if_valid),
        .d_req(b_d_req), .d_we(1'b0), .d_addr(b_d_addr), .d_wdata(8'h00),
        .d_gnt(b_d_gnt), .d_valid(b_d_valid), .rdata(b_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory for the MEM_LAT=1 instance.
    logic [7:0] mem_a [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_a[mem_addr] <= mem_wdata;
            else        mem_rdata       <= mem_a[mem_addr];
        end
    end

    // Memory for the MEM_LAT=4 instance: data is correct only in the 4th cycle after mem_en.
    logic [7:0] mem_b [256];
    logic [7:0] pipe_b [4];
    always @(posedge clk) begin
        pipe_b[0] <= b_mem_en ? mem_b[b_mem_addr] : 8'h00;
        for (int k = 1; k < 4; k++) pipe_b[k] <= pipe_b[k-1];
    end
    assign b_mem_rdata = pipe_b[3];

    // Transaction model: one access record with its grant cycle g.
    int         errors = 0, checks = 0, cyc = 0;
    bit         acc_v, own_d, a_we;
    int         g, starve;
    logic [7:0] a_rd, exp_rdata, exp_maddr, exp_mwdata;
    bit         exp_mwe;
    logic [7:0] refmem [256];
    string      glog;

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        acc_v = 0; g = -100; starve = 0; own_d = 0; a_we = 0;
        exp_rdata = 8'h00; exp_maddr = 8'h00; exp_mwdata = 8'h00; exp_mwe = 0;
    endtask

    function automatic bit model_idle();
        return !acc_v || cyc > g + LAT + 1;
    endfunction

    // Applied at the clock edge ending cycle cyc, with the inputs presented during cyc.
    task automatic model_edge();
        bit fw;
        if (acc_v && cyc == g + LAT && !a_we) exp_rdata = a_rd;
        if ((!acc_v || cyc >= g + LAT + 1) && (if_req || d_req)) begin
            fw    = if_req && (!d_req || starve == SMAX);
            acc_v = 1; g = cyc + 1; own_d = !fw;
            if (fw) begin
                exp_maddr = if_addr; exp_mwe = 0;
            end else begin
                exp_maddr = d_addr; exp_mwe = d_we; exp_mwdata = d_wdata;
            end
            a_we = exp_mwe;
            if (a_we) refmem[exp_maddr] = exp_mwdata;
            else      a_rd = refmem[exp_maddr];
            if (fw || !if_req) starve = 0;
            else if (starve < SMAX) starve++;
            if (fw) glog = {glog, "F"};
            else    glog = {glog, "D"};
        end
    endtask

    task automatic compare();
        bit iss, dn, bz;
        iss = acc_v && cyc == g;
        dn  = acc_v && cyc == g + LAT + 1;
        bz  = acc_v && cyc >= g && cyc <= g + LAT + 1;
        chk1("if_gnt", if_gnt, iss && !own_d);
        chk1("d_gnt", d_gnt, iss && own_d);
        chk1("mem_en", mem_en, iss);
        chk1("if_valid", if_valid, dn && !own_d);
        chk1("d_valid", d_valid, dn && own_d);
        chk1("busy", busy, bz);
        chk1("mem_we", mem_we, exp_mwe);
        chk8("mem_addr", mem_addr, exp_maddr);
        chk8("mem_wdata", mem_wdata, exp_mwdata);
        chk8("rdata", rdata, exp_rdata);
    endtask

    task automatic step();
        if (!rst) model_edge();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    // Requesters: hold until granted, then drop or re-request the cycle after gnt.
    task automatic auto_drive(input int p_if, input int p_d);
        bit f_gp, d_gp;
        f_gp = acc_v && (cyc - 1) == g && !own_d;
        d_gp = acc_v && (cyc - 1) == g && own_d;
        if (if_req ? f_gp : 1'b1) begin
            if_req = ($urandom_range(99) < p_if);
            if_addr = 8'($urandom);
        end
        if (d_req ? d_gp : 1'b1) begin
            d_req   = ($urandom_range(99) < p_d);
            d_we    = 1'($urandom_range(1));
            d_addr  = 8'($urandom);
            d_wdata = 8'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((if_req || d_req || !model_idle()) && n < 60) begin
            step();
            auto_drive(0, 0);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drain_timeout cyc=%0d got=busy exp=idle", cyc);
        end
    endtask

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem_a[i] = v; refmem[i] = v; mem_b[i] = 8'h00;
        end
        mem_a[8'h10] = 8'hA5; refmem[8'h10] = 8'hA5;
        mem_b[8'h22] = 8'h5E;
        for (int k = 0; k < 4; k++) pipe_b[k] = 8'h00;
        mem_rdata = 8'h00;

        rst = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        b_d_req = 0; b_d_addr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        chk1("b_busy_reset", b_busy, 1'b0);
        rst = 1'b0;

        // MEM_LAT=4 load: sampled in the 4th WAIT cycle, valid in cycle 6, busy 1..6.
        b_d_req = 1'b1; b_d_addr = 8'h22;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk1("b_busy", b_busy, k >= 1 && k <= 6);
            chk1("b_d_gnt", b_d_gnt, k == 1);
            chk1("b_mem_en", b_mem_en, k == 1);
            chk1("b_d_valid", b_d_valid, k == 6);
            if (k == 6) chk8("b_rdata", b_rdata, 8'h5E);
            if (k == 2) b_d_req = 1'b0;
        end

        // Single fetch from 8'h10.
        if_req = 1; if_addr = 8'h10;
        step();
        chk1("fetch_gnt", if_gnt, 1'b1);
        chk1("fetch_mem_en", mem_en, 1'b1);
        chk8("fetch_mem_addr", mem_addr, 8'h10);
        step(); if_req = 0;
        step();
        chk1("fetch_valid", if_valid, 1'b1);
        chk8("fetch_rdata", rdata, 8'hA5);
        drain();

        // Single store to 8'h80.
        d_req = 1; d_we = 1; d_addr = 8'h80; d_wdata = 8'h3C;
        step();
        chk1("store_gnt", d_gnt, 1'b1);
        chk1("store_mem_we", mem_we, 1'b1);
        chk8("store_mem_wdata", mem_wdata, 8'h3C);
        step(); d_req = 0;
        step();
        chk1("store_valid", d_valid, 1'b1);
        chk8("store_rdata_kept", rdata, 8'hA5);
        drain();

        // Both in the same IDLE cycle: data first, fetch three cycles later.
        if_req = 1; if_addr = 8'h44; d_req = 1; d_we = 0; d_addr = 8'h55;
        step();
        chk1("both_d_first", d_gnt, 1'b1);
        step(); d_req = 0;
        step();
        step();
        chk1("both_f_second", if_gnt, 1'b1);
        step(); if_req = 0;
        drain();

        // Continuous pressure from both requesters.
        glog = "";
        for (int n = 0; n < 100 && glog.len() < 8; n++) begin
            step();
            auto_drive(100, 100);
        end
        checks++;
        if (glog != "DDDFDDDF") begin
            errors++;
            $display("FAIL starve_order got=%s exp=DDDFDDDF", glog);
        end
        drain();

        // Reset during WAIT abandons the access; a fresh fetch then completes.
        if_req = 1; if_addr = 8'h33;
        step();
        step(); if_req = 0;
        chk1("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk8("rst_mem_addr", mem_addr, 8'h00);
        model_reset();
        step();
        step();
        rst = 1'b0;
        if_req = 1; if_addr = 8'h10;
        step();
        step(); if_req = 0;
        step();
        chk1("post_rst_valid", if_valid, 1'b1);
        chk8("post_rst_rdata", rdata, 8'hA5);
        drain();

        // Randomized mixed traffic.
        for (int n = 0; n < 3000; n++) begin
            step();
            auto_drive(35, 45);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
